// File: rtl/alu_iter_exec.sv
// Iterative ALU: single-cycle logic/arithmetic ops, shifts stepped one bit per cycle.
// Latency 1 cycle for non-shift ops and zero shifts, shamt+1 cycles for shifts.
// One op in flight; IN_READY only in IDLE, result held in DONE until OUT_READY.
module alu_iter_exec #(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [3:0]       ALUSelection,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             BUSY
);

   // Operation encodings shared with the rest of the datapath
   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [3:0]       op_q, op_d;

   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] comb_res;
   logic [WIDTH-1:0] shifted;
   logic             is_shift;

   assign shamt = B[SHW-1:0];

   // Single-cycle result for the incoming request; shifts pass A through for the zero-shift case
   always_comb begin
      comb_res = '0;
      is_shift = 1'b0;
      case (ALUSelection)
         OP_ADD:  comb_res = A + B;
         OP_SUB:  comb_res = A - B;
         OP_XOR:  comb_res = A ^ B;
         OP_OR:   comb_res = A | B;
         OP_AND:  comb_res = A & B;
         OP_SLT:  comb_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
         OP_SLTU: comb_res = {{(WIDTH-1){1'b0}}, (A < B)};
         OP_SLL, OP_SRL, OP_SRA: begin
            comb_res = A;
            is_shift = 1'b1;
         end
         default: comb_res = '0;
      endcase
   end

   // One-bit shift step of the work register, fill chosen by the captured opcode
   always_comb begin
      case (op_q)
         OP_SLL:  shifted = {work_q[WIDTH-2:0], 1'b0};
         OP_SRA:  shifted = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
         default: shifted = {1'b0, work_q[WIDTH-1:1]};
      endcase
   end

   // Next-state and handshake outputs
   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      work_d    = work_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      IN_READY  = 1'b0;
      OUT_VALID = 1'b0;
      BUSY      = 1'b0;
      case (state_q)
         S_IDLE: begin
            IN_READY = 1'b1;
            if (IN_VALID) begin
               op_d = ALUSelection;
               if (is_shift && (shamt != '0)) begin
                  work_d  = A;
                  cnt_d   = shamt;
                  state_d = S_SHIFT;
               end else begin
                  result_d = comb_res;
                  state_d  = S_DONE;
               end
            end
         end
         S_SHIFT: begin
            BUSY   = 1'b1;
            work_d = shifted;
            cnt_d  = cnt_q - 1'b1;
            // Last step: publish the final shifted value as the result
            if (cnt_q == SHW'(1)) begin
               result_d = shifted;
               state_d  = S_DONE;
            end
         end
         S_DONE: begin
            OUT_VALID = 1'b1;
            if (OUT_READY) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State registers; reset aborts any op in flight
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= S_IDLE;
         result_q <= '0;
         work_q   <= '0;
         cnt_q    <= '0;
         op_q     <= '0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         work_q   <= work_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
      end
   end

   assign RESULT = result_q;
   assign ZERO   = (result_q == '0);

endmodule

// File: tb/tb_alu_iter_exec.sv
// Self-checking bench for alu_iter_exec: directed corner cases plus random ops vs a reference model.
// Inputs driven 1 time unit after the rising edge, outputs sampled there too.
// Exercises output stall, input ignore while busy, and reset aborts.
module tb_alu_iter_exec;

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_AND  = 4'd4;
   localparam logic [3:0] OP_SLT  = 4'd5;
   localparam logic [3:0] OP_SLTU = 4'd6;
   localparam logic [3:0] OP_SLL  = 4'd7;
   localparam logic [3:0] OP_SRL  = 4'd8;
   localparam logic [3:0] OP_SRA  = 4'd9;

   logic        CLK;
   logic        RST_N;
   logic        IN_VALID;
   logic        IN_READY;
   logic [31:0] A;
   logic [31:0] B;
   logic [3:0]  ALUSelection;
   logic        OUT_VALID;
   logic        OUT_READY;
   logic [31:0] RESULT;
   logic        ZERO;
   logic        BUSY;

   int n_cmp = 0;
   int n_err = 0;

   alu_iter_exec #(.WIDTH(32)) dut (
      .CLK          (CLK),
      .RST_N        (RST_N),
      .IN_VALID     (IN_VALID),
      .IN_READY     (IN_READY),
      .A            (A),
      .B            (B),
      .ALUSelection (ALUSelection),
      .OUT_VALID    (OUT_VALID),
      .OUT_READY    (OUT_READY),
      .RESULT       (RESULT),
      .ZERO         (ZERO),
      .BUSY         (BUSY)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference result straight from the operation definitions
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b[4:0]);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_XOR:  return a ^ b;
         OP_OR:   return a | b;
         OP_AND:  return a & b;
         OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
         OP_SLL:  return a << sh;
         OP_SRL:  return a >> sh;
         OP_SRA:  return 32'($signed(a) >>> sh);
         default: return 32'd0;
      endcase
   endfunction

   function automatic int ref_lat(input logic [3:0] op, input logic [31:0] b);
      if ((op == OP_SLL || op == OP_SRL || op == OP_SRA) && b[4:0] != 5'd0)
         return int'(b[4:0]) + 1;
      return 1;
   endfunction

   // Issue one op, count latency/BUSY cycles, stall the output for 'hold' cycles, then retire
   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
      logic [31:0] exp_r;
      int exp_lat;
      int lat;
      int busy_n;
      int ready_seen;
      exp_r   = ref_alu(op, a, b);
      exp_lat = ref_lat(op, b);
      chk("in_ready_idle", IN_READY, 1);
      IN_VALID = 1'b1; A = a; B = b; ALUSelection = op;
      OUT_READY = (hold == 0);
      @(posedge CLK); #1;
      IN_VALID = 1'b0; A = $urandom; B = $urandom; ALUSelection = 4'($urandom);
      lat = 1; busy_n = 0; ready_seen = 0;
      while (!OUT_VALID && lat < 100) begin
         if (BUSY) busy_n++;
         if (IN_READY) ready_seen++;
         A = $urandom; B = $urandom;
         @(posedge CLK); #1;
         lat++;
      end
      chk("latency", lat, exp_lat);
      chk("busy_cycles", busy_n, exp_lat - 1);
      chk("in_ready_while_busy", ready_seen, 0);
      chk("result", RESULT, exp_r);
      chk("zero", ZERO, (exp_r == 32'd0));
      chk("in_ready_done", IN_READY, 0);
      for (int i = 0; i < hold; i++) begin
         IN_VALID = 1'b1; A = $urandom; B = $urandom; ALUSelection = 4'($urandom);
         @(posedge CLK); #1;
         chk("hold_valid", OUT_VALID, 1);
         chk("hold_result", RESULT, exp_r);
         chk("hold_in_ready", IN_READY, 0);
      end
      IN_VALID = 1'b0;
      OUT_READY = 1'b1;
      @(posedge CLK); #1;
      chk("retire_valid", OUT_VALID, 0);
      chk("retire_in_ready", IN_READY, 1);
      OUT_READY = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 RST_N = 1'b0;
      #1;
      chk("rst_in_ready", IN_READY, 1);
      chk("rst_out_valid", OUT_VALID, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_result", RESULT, 0);
      chk("rst_zero", ZERO, 1);
      #2 RST_N = 1'b1;
   endtask

   task automatic expect_silence(input string tag);
      int ov_seen;
      ov_seen = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge CLK); #1;
         if (OUT_VALID || BUSY) ov_seen++;
      end
      chk(tag, ov_seen, 0);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;

      RST_N = 1'b0; IN_VALID = 1'b1; A = 32'd3; B = 32'd4;
      ALUSelection = OP_ADD; OUT_READY = 1'b1;
      #1;
      chk("reset_in_ready", IN_READY, 1);
      chk("reset_out_valid", OUT_VALID, 0);
      chk("reset_busy", BUSY, 0);
      chk("reset_zero", ZERO, 1);
      chk("reset_result", RESULT, 0);
      #21 RST_N = 1'b1;
      @(posedge CLK); #1;
      chk("first_accept_valid", OUT_VALID, 1);
      chk("first_accept_result", RESULT, 32'd7);
      IN_VALID = 1'b0;
      @(posedge CLK); #1;
      OUT_READY = 1'b0;

      run_op(OP_ADD,  32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SRA,  32'h8000_0000, 32'd31, 0);
      run_op(OP_SRL,  32'h8000_0000, 32'd31, 0);
      run_op(OP_SLL,  32'h1234_5678, 32'h0000_0020, 0);
      run_op(OP_SLT,  32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0);
      run_op(OP_SUB,  32'd5, 32'd7, 4);
      run_op(4'd12,   32'hDEAD_BEEF, 32'h1234_5678, 1);
      run_op(OP_SRA,  32'h4000_0000, 32'hFFFF_FFE3, 2);

      // Reset during the fifth SHIFT cycle of a 10-bit left shift
      IN_VALID = 1'b1; A = 32'd1; B = 32'd10; ALUSelection = OP_SLL;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge CLK); #1;
      end
      chk("abort_busy_before", BUSY, 1);
      pulse_reset();
      expect_silence("abort_shift_no_result");

      // Reset while a result is stalled in DONE
      @(posedge CLK); #1;
      IN_VALID = 1'b1; A = 32'd9; B = 32'd9; ALUSelection = OP_ADD; OUT_READY = 1'b0;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      chk("abort_done_valid_before", OUT_VALID, 1);
      pulse_reset();
      expect_silence("abort_done_no_result");
      @(posedge CLK); #1;

      for (int n = 0; n < 40; n++) begin
         op = 4'($urandom_range(0, 15));
         a  = $urandom;
         b  = $urandom;
         if (n % 4 == 0) a = 32'h8000_0000 | a;
         if (n % 5 == 0) b = b & 32'hFFFF_FFE0;
         run_op(op, a, b, $urandom_range(0, 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/alu_iter_exec.md
ALU_ITER_EXEC -- requirements
Module: alu_iter_exec

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand and result width in bits.
REQ-002 SHALL have parameter: SHW, $clog2(WIDTH), shift-amount width (taken from B[SHW-1:0]).
REQ-003 SHALL have port: CLK  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port: IN_VALID  input  1  operation request valid.
REQ-006 SHALL have port: IN_READY  output  1  block can accept a request.
REQ-007 SHALL have port: A  input  WIDTH  operand 1 (rs1).
REQ-008 SHALL have port: B  input  WIDTH  operand 2 (rs2 or immediate).
REQ-009 SHALL have port: ALUSelection  input  4  operation code, encodings per operation_type.sv.
REQ-010 SHALL have port: OUT_VALID  output  1  RESULT/ZERO valid.
REQ-011 SHALL have port: OUT_READY  input  1  consumer accepts result.
REQ-012 SHALL have port: RESULT  output  WIDTH  operation result.
REQ-013 SHALL have port: ZERO  output  1  RESULT == 0.
REQ-014 SHALL have port: BUSY  output  1  high in SHIFT state.

Function
REQ-015 SHALL implement FSM states IDLE, SHIFT, DONE; IN_READY = 1 only in IDLE; OUT_VALID = 1 only in DONE.
REQ-016 SHALL accept a request on a rising edge with IN_VALID && IN_READY, capturing A, B, ALUSelection, and shamt = B[SHW-1:0].
REQ-017 For ADD, SUB, XOR, OR, AND, LESS_THAN_SIGNED, LESS_THAN_UNSIGNED: SHALL compute at accept and go IDLE->DONE; OUT_VALID high the cycle after accept (latency 1).
REQ-018 ADD/SUB SHALL wrap modulo 2^WIDTH; no overflow flag.
REQ-019 LESS_THAN_SIGNED/UNSIGNED SHALL yield RESULT = {WIDTH-1 zeros, flag}, flag from two's-complement/unsigned compare.
REQ-020 For LEFT_SHIFT_UNSIGNED, RIGHT_SHIFT_UNSIGNED, RIGHT_SHIFT_SIGNED with shamt != 0: SHALL load A into a work register and enter SHIFT; shift by 1 bit per cycle, decrementing a counter from shamt; go to DONE when the counter reaches 0; latency = shamt + 1 cycles.
REQ-021 Shift fill: left shift inserts 0 at LSB; unsigned right shift inserts 0 at MSB; signed right shift replicates current MSB.
REQ-022 Shift with shamt == 0 SHALL go IDLE->DONE with RESULT = A (latency 1); B bits above SHW-1 ignored.
REQ-023 Unrecognised ALUSelection SHALL go IDLE->DONE with RESULT = 0, ZERO = 1.
REQ-024 In DONE, RESULT and ZERO SHALL hold stable until OUT_VALID && OUT_READY; then go to IDLE on that edge.
REQ-025 A, B, ALUSelection changes while not in IDLE SHALL have no effect.
REQ-026 IN_VALID while not IN_READY SHALL be ignored; the upstream holds the request.
REQ-027 No back-to-back overlap: a new request SHALL be accepted no earlier than the cycle after DONE is left (minimum 2 cycles per op).
REQ-028 ZERO SHALL be derived combinationally from registered RESULT.
REQ-029 BUSY SHALL be high exactly during SHIFT cycles (shamt cycles per shift op).

Reset
REQ-030 RST_N low SHALL immediately force state IDLE, RESULT = 0, shift counter = 0, work register = 0, independent of CLK.
REQ-031 During reset: IN_READY = 1, OUT_VALID = 0, BUSY = 0, ZERO = 1.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abort the operation; no result is delivered after release.
REQ-033 First request SHALL be accepted on the first rising edge with RST_N high and IN_VALID high.

Verification
REQ-034 ADD A=0xFFFFFFFF, B=1, OUT_READY=1 -> OUT_VALID 1 cycle after accept, RESULT=0x00000000, ZERO=1; IN_READY back next cycle.
REQ-035 RIGHT_SHIFT_SIGNED A=0x80000000, B=31 -> BUSY high 31 cycles, OUT_VALID at cycle 32, RESULT=0xFFFFFFFF; repeat with RIGHT_SHIFT_UNSIGNED -> 0x00000001.
REQ-036 LEFT_SHIFT_UNSIGNED A=0x12345678, B=0x00000020 (shamt 0) -> latency 1, RESULT=0x12345678.
REQ-037 LESS_THAN_SIGNED A=0xFFFFFFFF, B=1 -> RESULT=1; LESS_THAN_UNSIGNED same operands -> RESULT=0, ZERO=1.
REQ-038 SUB A=5, B=7 with OUT_READY low 4 cycles -> RESULT=0xFFFFFFFE held, OUT_VALID high, IN_READY low, A/B toggling ignored; retires on OUT_READY.
REQ-039 LEFT_SHIFT_UNSIGNED A=1, B=10, RST_N pulsed low at SHIFT cycle 5 -> immediate IDLE, RESULT=0, OUT_VALID never asserted for that op.
